// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional parity, stop bit. Each bit lasts PRESCALE clocks. A single-entry
// holding register lets the next byte queue while the current frame shifts,
// so that consecutive frames go out back-to-back.
module uart_tx_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   DATA_VALID,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    output logic                   TX_OUT,
    output logic                   IN_READY,
    output logic                   BUSY,
    output logic                   FRAME_DONE
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_hold_full;
    logic [DATA_WIDTH-1:0]  r_hold_data;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [PRESC_WIDTH-1:0] r_cnt;
    logic [PRESC_WIDTH-1:0] r_presc;
    logic [BW-1:0]          r_bit_idx;
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   w_load;
    logic                   w_bit_end;
    logic                   w_last_bit;
    logic [PRESC_WIDTH-1:0] w_presc_eff;

    // Very small prescales would make the bit-end compare degenerate, so clamp to 4.
    assign w_presc_eff = (PRESCALE < PRESC_WIDTH'(4)) ? PRESC_WIDTH'(4) : PRESCALE;
    assign w_bit_end   = (r_cnt == r_presc - PRESC_WIDTH'(1));
    assign w_last_bit  = (r_bit_idx == BW'(DATA_WIDTH - 1));
    assign IN_READY    = !r_hold_full;

    // Holding register: accept only when empty; drained by the FSM load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (DATA_VALID && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold_data <= P_DATA;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, load strobe and line outputs, all decoded from registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        TX_OUT      = 1'b1;
        BUSY        = 1'b1;
        FRAME_DONE  = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                TX_OUT = 1'b0;
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                TX_OUT = r_shift[0];
                if (w_bit_end && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                TX_OUT = r_par_bit;
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                FRAME_DONE = w_bit_end;
                if (w_bit_end) begin
                    // A queued byte starts right away, with no idle bit in between.
                    if (r_hold_full) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                BUSY        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame datapath: config is captured at load so mid-frame changes cannot disturb it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_presc   <= PRESC_WIDTH'(4);
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_presc   <= w_presc_eff;
            r_bit_idx <= '0;
            r_shift   <= r_hold_data;
            r_par_en  <= PAR_EN;
            r_par_bit <= (^r_hold_data) ^ PAR_TYP;
        end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a table of single frames with
// hand-computed line images, plus sequences for reset, back-to-back,
// overflow and mid-frame configuration changes.
module tb_uart_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       IN_READY;
    logic       BUSY;
    logic       FRAME_DONE;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_serializer #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .IN_READY   (IN_READY),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // line image: bit 0 = start, then data LSB first, then parity (if any), then stop
    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [5:0]  presc;
        int          eff;
        int          nbits;
        logic [10:0] line;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue one byte from idle and check the acceptance latency.
    task automatic send(input logic [7:0] d, input string name);
        int w = 0;
        while (IN_READY !== 1'b1 && w < 2000) begin
            tick();
            w++;
        end
        chk({name, " ready_wait"}, 32'(w < 2000), 32'd1);
        P_DATA     = d;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        chk({name, " in_ready_n1"}, 32'(IN_READY), 32'd0);
        chk({name, " busy_n1"}, 32'(BUSY), 32'd0);
        tick();
        chk({name, " in_ready_n2"}, 32'(IN_READY), 32'd1);
    endtask

    // Called on the first cycle of a frame; returns on its last cycle.
    task automatic check_frame(input logic [10:0] line, input int nbits, input int presc,
                               input string name);
        int lerr = 0;
        int berr = 0;
        int derr = 0;
        int len  = nbits * presc;
        for (int i = 0; i < len; i++) begin
            if (i > 0) tick();
            if (TX_OUT !== line[i / presc]) lerr++;
            if (BUSY !== 1'b1) berr++;
            if (FRAME_DONE !== (i == len - 1)) derr++;
        end
        chk({name, " line_errs"}, 32'(lerr), 32'd0);
        chk({name, " busy_errs"}, 32'(berr), 32'd0);
        chk({name, " done_errs"}, 32'(derr), 32'd0);
    endtask

    task automatic check_idle(input string name);
        chk({name, " idle_busy"}, 32'(BUSY), 32'd0);
        chk({name, " idle_tx"}, 32'(TX_OUT), 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'hAA, 1'b1, 1'b0, 6'd32, 32, 11, 11'b10101010100, "aa_even_p32"};
        vecs[1] = '{8'hFB, 1'b1, 1'b1, 6'd16, 16, 11, 11'b10111110110, "fb_odd_p16"};
        vecs[2] = '{8'h04, 1'b0, 1'b0, 6'd16, 16, 10, 11'b01000001000, "04_nopar_p16"};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 6'd8,  8,  11, 11'b10000000000, "00_even_p8"};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 6'd8,  8,  11, 11'b11111111110, "ff_odd_p8"};
        vecs[5] = '{8'h81, 1'b0, 1'b1, 6'd16, 16, 10, 11'b01100000010, "81_nopar_p16"};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 6'd2,  4,  10, 11'b01001111000, "3c_clamp_p2"};
        vecs[7] = '{8'h13, 1'b1, 1'b1, 6'd8,  8,  11, 11'b10000100110, "13_odd_p8"};

        RST        = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        PRESCALE   = 6'd8;

        // reset at start
        tick();
        chk("rst0 tx", 32'(TX_OUT), 32'd1);
        chk("rst0 busy", 32'(BUSY), 32'd0);
        chk("rst0 in_ready", 32'(IN_READY), 32'd1);
        chk("rst0 done", 32'(FRAME_DONE), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // single frames from the table
        for (int v = 0; v < 8; v++) begin
            PAR_EN   = vecs[v].par_en;
            PAR_TYP  = vecs[v].par_typ;
            PRESCALE = vecs[v].presc;
            send(vecs[v].data, vecs[v].name);
            check_frame(vecs[v].line, vecs[v].nbits, vecs[v].eff, vecs[v].name);
            tick();
            check_idle(vecs[v].name);
            chk({vecs[v].name, " idle_ready"}, 32'(IN_READY), 32'd1);
        end

        // reset mid-frame, with a byte already queued
        PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 6'd8;
        send(8'h00, "rstmid");
        tick();
        P_DATA = 8'h5A; DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        chk("rstmid queued", 32'(IN_READY), 32'd0);
        chk("rstmid tx_start", 32'(TX_OUT), 32'd0);
        RST = 1'b1;
        tick();
        chk("rstmid tx", 32'(TX_OUT), 32'd1);
        chk("rstmid busy", 32'(BUSY), 32'd0);
        chk("rstmid in_ready", 32'(IN_READY), 32'd1);
        chk("rstmid done", 32'(FRAME_DONE), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        begin
            int bcnt = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (BUSY !== 1'b0 || TX_OUT !== 1'b1) bcnt++;
            end
            chk("rstmid stays_idle", 32'(bcnt), 32'd0);
        end

        // back-to-back 0xCC then 0x13, with an overflow attempt (0x55) while full
        PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 6'd8;
        send(8'hCC, "b2b1");
        fork
            begin
                check_frame(11'b10110011000, 11, 8, "b2b1");
                chk("b2b last_in_ready", 32'(IN_READY), 32'd0);
                tick();
                chk("b2b second_in_ready", 32'(IN_READY), 32'd1);
                check_frame(11'b11000100110, 11, 8, "b2b2");
                tick();
                check_idle("b2b");
            end
            begin
                repeat (20) tick();
                P_DATA = 8'h13; DATA_VALID = 1'b1;
                chk("b2b accept_ready", 32'(IN_READY), 32'd1);
                tick();
                P_DATA = 8'h55;
                chk("ovf in_ready", 32'(IN_READY), 32'd0);
                tick();
                DATA_VALID = 1'b0;
            end
        join

        // config stability: change PRESCALE and PAR_TYP mid-frame
        PAR_EN = 1'b1; PAR_TYP = 1'b0; PRESCALE = 6'd32;
        send(8'hAA, "cfg1");
        fork
            begin
                check_frame(11'b10101010100, 11, 32, "cfg1");
                tick();
                check_frame(11'b10111110110, 11, 8, "cfg2");
                tick();
                check_idle("cfg");
            end
            begin
                repeat (5) tick();
                PRESCALE = 6'd8;
                PAR_TYP  = 1'b1;
                repeat (3) tick();
                P_DATA = 8'hFB; DATA_VALID = 1'b1;
                tick();
                DATA_VALID = 1'b0;
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
